// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, instruction-memory addressing and the IF/ID pipeline register.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0033
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_pc_plus4,
  output logic [31:0]       if_inst,
  output logic              if_valid,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_flush_cnt
);

  logic [31:0] pc;

  // Word address; pc bits above ADDR_W+1 simply alias into the memory.
  assign imem_addr   = pc[ADDR_W+1:2];
  assign if_pc_plus4 = if_pc + 32'd4;

  // A redirect overrides a stall: the IF/ID slot is squashed either way.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      if_pc    <= 32'h0;
      if_inst  <= NOP_INST;
      if_valid <= 1'b0;
    end else if (branch_taken) begin
      pc       <= branch_target & ~32'h3;
      if_pc    <= 32'h0;
      if_inst  <= NOP_INST;
      if_valid <= 1'b0;
    end else if (!stall) begin
      pc       <= pc + 32'd4;
      if_pc    <= pc;
      if_inst  <= imem_data;
      if_valid <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt <= 32'h0;
      flush_cnt <= 32'h0;
    end else if (branch_taken) begin
      flush_cnt <= flush_cnt + 32'd1;
    end else if (!stall) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt;
  assign perf_flush_cnt = flush_cnt;
`else
  assign perf_fetch_cnt = 32'h0;
  assign perf_flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: abstract reference model compared every cycle plus directed literal checks.
module tb_fetch_unit;
  localparam int          ADDR_W   = 6;
  localparam int          DEPTH    = 1 << ADDR_W;
  localparam logic [31:0] NOP      = 32'h0000_0033;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              stall = 1'b0;
  logic              branch_taken = 1'b0;
  logic [31:0]       branch_target = 32'h0;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic [31:0]       if_pc, if_pc_plus4, if_inst;
  logic              if_valid;
  logic [31:0]       perf_fetch_cnt, perf_flush_cnt;

  logic [31:0] mem [DEPTH];

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(32'h0), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_inst(if_inst), .if_valid(if_valid),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  assign imem_data = mem[imem_addr];

  // Reference model: architectural state in plain integers.
  longint unsigned m_pc;
  longint unsigned m_if_pc;
  logic [31:0]     m_if_inst;
  bit              m_if_valid;
  int unsigned     m_fetches, m_flushes;
  bit              m_ok = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc <= 0; m_if_pc <= 0; m_if_inst <= NOP; m_if_valid <= 0;
      m_fetches <= 0; m_flushes <= 0; m_ok <= 1;
    end else if (branch_taken) begin
      m_pc <= (longint'(branch_target) / 4) * 4;
      m_if_pc <= 0; m_if_inst <= NOP; m_if_valid <= 0;
      m_flushes <= m_flushes + 1;
    end else if (!stall) begin
      m_if_pc <= m_pc;
      m_if_inst <= mem[(m_pc / 4) % DEPTH];
      m_if_valid <= 1;
      m_pc <= (m_pc + 4) % 64'h1_0000_0000;
      m_fetches <= m_fetches + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge once the model has seen reset.
  always @(negedge clk) begin
    if (m_ok) begin
      check("model_imem_addr", 32'(imem_addr), 32'((m_pc / 4) % DEPTH));
      check("model_if_pc", if_pc, m_if_pc[31:0]);
      check("model_if_pc_plus4", if_pc_plus4, 32'((m_if_pc + 4) % 64'h1_0000_0000));
      check("model_if_inst", if_inst, m_if_inst);
      check("model_if_valid", 32'(if_valid), 32'(m_if_valid));
`ifdef FETCH_PERF_CNT_EN
      check("model_fetch_cnt", perf_fetch_cnt, m_fetches);
      check("model_flush_cnt", perf_flush_cnt, m_flushes);
`else
      check("model_fetch_cnt", perf_fetch_cnt, 32'h0);
      check("model_flush_cnt", perf_flush_cnt, 32'h0);
`endif
    end
  end

  // driver
  task automatic step(input logic s, input logic b, input logic [31:0] t);
    stall = s; branch_taken = b; branch_target = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA000_0000 | i;

    // reset and start-up
    step(0, 0, 0);
    step(0, 0, 0);
    rst_n = 1'b1;
    check("rst_imem_addr", 32'(imem_addr), 32'h0);
    check("rst_if_valid", 32'(if_valid), 32'h0);
    check("rst_if_inst", if_inst, NOP);
    step(0, 0, 0);
    check("first_if_pc", if_pc, 32'h0);
    check("first_if_inst", if_inst, 32'hA000_0000);
    check("first_if_valid", 32'(if_valid), 32'h1);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    check("fifth_if_pc", if_pc, 32'h10);
    check("fifth_if_pc_plus4", if_pc_plus4, 32'h14);

    // stall at pc=0x0C
    rst_n = 1'b0;
    step(0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    check("pre_stall_imem_addr", 32'(imem_addr), 32'h3);
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0);
      check("stall_if_pc", if_pc, 32'h8);
      check("stall_imem_addr", 32'(imem_addr), 32'h3);
    end
    step(0, 0, 0);
    check("post_stall_if_pc", if_pc, 32'hC);
    check("post_stall_if_inst", if_inst, 32'hA000_0003);

    // redirect wins over stall, misaligned target
    step(1, 1, 32'h22);
    check("redir_imem_addr", 32'(imem_addr), 32'h8);
    check("redir_if_inst", if_inst, NOP);
    check("redir_if_valid", 32'(if_valid), 32'h0);
    check("redir_if_pc", if_pc, 32'h0);
    step(0, 0, 0);
    check("target_if_pc", if_pc, 32'h20);
    check("target_if_inst", if_inst, 32'hA000_0008);

    // memory and pc wrap
    step(0, 1, 32'hFC);
    check("wrap_imem_addr_63", 32'(imem_addr), 32'd63);
    step(0, 0, 0);
    check("wrap_imem_addr_0", 32'(imem_addr), 32'h0);
    check("wrap_if_pc", if_pc, 32'hFC);
    check("wrap_if_inst", if_inst, 32'hA000_003F);
    step(0, 1, 32'hFFFF_FFFC);
    check("top_imem_addr", 32'(imem_addr), 32'd63);
    step(0, 0, 0);
    check("top_if_pc", if_pc, 32'hFFFF_FFFC);
    check("top_if_pc_plus4", if_pc_plus4, 32'h0);
    check("top_imem_addr_wrap", 32'(imem_addr), 32'h0);

    // reset during redirect
    rst_n = 1'b0;
    step(1, 1, 32'h40);
    check("midrst_imem_addr", 32'(imem_addr), 32'h0);
    check("midrst_if_valid", 32'(if_valid), 32'h0);
    check("midrst_fetch_cnt", perf_fetch_cnt, 32'h0);
    check("midrst_flush_cnt", perf_flush_cnt, 32'h0);
    rst_n = 1'b1;

    // counters: 10 fetches, 2 stalls, 1 redirect
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 1, 32'h80);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch", perf_fetch_cnt, 32'd10);
    check("perf_flush", perf_flush_cnt, 32'd1);
`else
    check("perf_fetch", perf_fetch_cnt, 32'd0);
    check("perf_flush", perf_flush_cnt, 32'd0);
`endif

    // mixed directed sequence checked by the model
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 1, 32'h0000_0107);
    step(0, 0, 0);
    step(1, 1, 32'h0000_0010);
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    check("mix_if_pc", if_pc, 32'h18);
    check("mix_if_inst", if_inst, 32'hA000_0006);
    step(0, 0, 0);
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
